// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge
// Request/response bridge between the core load/store port and a byte-wide
// synchronous memory. One core access (1, 2, 4 or 8 bytes) is serialised into
// little-endian byte transactions. Load data is sign- or zero-extended before
// it is returned.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready_o handshake for one core access
//   req_we_i           1 = store, 0 = load
//   req_size_i         log2 of access bytes (3 acts as 2 when LEN = 32)
//   req_unsigned_i     zero-extend load data when set
//   req_addr_i         starting byte address (wraps modulo 2^ADDR_WIDTH)
//   req_wdata_i        store data, byte k at bits [8k+7:8k]
//   resp_valid_o       one-cycle completion pulse
//   resp_rdata_o       extended load data, held until the next load response
//   mem_addr_o/we_o/wdata_o/rdata_i  byte memory port (read data one cycle late)
module mem_byte_bridge #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN-1:0]        req_wdata_i,
  output logic                  resp_valid_o,
  output logic [LEN-1:0]        resp_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [BYTE_SIZE-1:0]  mem_wdata_o,
  input  logic [BYTE_SIZE-1:0]  mem_rdata_i
);

  localparam int NBYTES = LEN / 8;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [LEN-1:0]        rbuf_q, rbuf_d;
  logic [LEN-1:0]        resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [BYTE_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  active_q;
  logic [3:0]            n_last;

  // Fill everything above the accessed bytes with the access's top bit
  // (signed) or zero (unsigned).
  function automatic logic [LEN-1:0] extend(input logic [LEN-1:0] v,
                                            input logic [1:0] sz,
                                            input logic uns);
    logic           fill;
    int             nbits;
    logic [LEN-1:0] r;
    case (sz)
      2'd0:    fill = v[7];
      2'd1:    fill = v[15];
      2'd2:    fill = v[31];
      default: fill = v[LEN-1];
    endcase
    if (uns) fill = 1'b0;
    nbits = 32'd8 << sz;
    for (int i = 0; i < LEN; i++) r[i] = (i < nbits) ? v[i] : fill;
    return r;
  endfunction

  always_comb begin
    case (size_q)
      2'd0:    n_last = 4'd0;
      2'd1:    n_last = 4'd1;
      2'd2:    n_last = 4'd3;
      default: n_last = 4'd7;
    endcase
  end

  // The memory port is registered: the byte for index k is set up on the edge
  // that enters cycle k, so the memory sees it on the following edge.
  // k_q is the index currently on the bus; in LOAD the extra drain step
  // (k_q == n_last + 1) only collects the final read byte.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = active_q;
      end
      STORE: begin
        if (k_q == n_last) begin
          state_d = RESP;
        end else begin
          mem_we_d   = 1'b1;
          k_d        = k_q + 4'd1;
          mem_addr_d = addr_q + ADDR_WIDTH'(k_q + 4'd1);
          for (int b = 0; b < NBYTES; b++)
            if (b == int'(k_q) + 1) mem_wdata_d = wdata_q[8*b +: 8];
        end
      end
      LOAD: begin
        for (int b = 0; b < NBYTES; b++)
          if (b == int'(k_q) - 1) rbuf_d[8*b +: 8] = mem_rdata_i;
        if (k_q == n_last + 4'd1) begin
          state_d      = RESP;
          resp_rdata_d = extend(rbuf_d, size_q, uns_q);
        end else begin
          k_d = k_q + 4'd1;
          if (k_q != n_last) mem_addr_d = addr_q + ADDR_WIDTH'(k_q + 4'd1);
        end
      end
      RESP: begin
        req_ready_o  = 1'b1;
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting also covers RESP, which gives back-to-back operation.
    if (req_ready_o && req_valid_i) begin
      addr_d      = req_addr_i;
      size_d      = (LEN == 32 && req_size_i == 2'd3) ? 2'd2 : req_size_i;
      uns_d       = req_unsigned_i;
      wdata_d     = req_wdata_i;
      k_d         = 4'd0;
      mem_addr_d  = req_addr_i;
      mem_we_d    = req_we_i;
      mem_wdata_d = req_wdata_i[BYTE_SIZE-1:0];
      state_d     = req_we_i ? STORE : LOAD;
    end
  end

  // active_q keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      k_q          <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      active_q     <= 1'b1;
    end
  end

  assign resp_rdata_o = resp_rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Testbench for mem_byte_bridge: a 32-bit and a 64-bit instance, each with its
// own byte memory model (synchronous, read data one cycle after the address).
// Latencies are counted in clock edges from the accept edge to the edge that
// consumes the resp_valid pulse.
module tb_mem_byte_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance signals
  logic        rv32 = 1'b0, rr32, rwe32 = 1'b0, run32 = 1'b0, respv32, mwe32;
  logic [1:0]  rsz32 = 2'd0;
  logic [16:0] raddr32 = '0, maddr32;
  logic [31:0] rwd32 = '0, rdata32;
  logic [7:0]  mwd32, mrd32;

  // 64-bit instance signals
  logic        rv64 = 1'b0, rr64, rwe64 = 1'b0, run64 = 1'b0, respv64, mwe64;
  logic [1:0]  rsz64 = 2'd0;
  logic [16:0] raddr64 = '0, maddr64;
  logic [63:0] rwd64 = '0, rdata64;
  logic [7:0]  mwd64, mrd64;

  // Memory models with a backdoor write port for preloading.
  logic [7:0]  mem32 [0:131071];
  logic [7:0]  mem64 [0:131071];
  logic        bd_we32 = 1'b0, bd_we64 = 1'b0;
  logic [16:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  int          wr_count32 = 0;

  mem_byte_bridge #(.LEN(32), .ADDR_WIDTH(17), .BYTE_SIZE(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv32), .req_ready_o(rr32), .req_we_i(rwe32),
    .req_size_i(rsz32), .req_unsigned_i(run32), .req_addr_i(raddr32),
    .req_wdata_i(rwd32), .resp_valid_o(respv32), .resp_rdata_o(rdata32),
    .mem_addr_o(maddr32), .mem_we_o(mwe32), .mem_wdata_o(mwd32),
    .mem_rdata_i(mrd32)
  );

  mem_byte_bridge #(.LEN(64), .ADDR_WIDTH(17), .BYTE_SIZE(8)) dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv64), .req_ready_o(rr64), .req_we_i(rwe64),
    .req_size_i(rsz64), .req_unsigned_i(run64), .req_addr_i(raddr64),
    .req_wdata_i(rwd64), .resp_valid_o(respv64), .resp_rdata_o(rdata64),
    .mem_addr_o(maddr64), .mem_we_o(mwe64), .mem_wdata_o(mwd64),
    .mem_rdata_i(mrd64)
  );

  always @(posedge clk) begin
    if (bd_we32) mem32[bd_addr] <= bd_data;
    else if (mwe32) begin
      mem32[maddr32] <= mwd32;
      wr_count32 <= wr_count32 + 1;
    end
    mrd32 <= mem32[maddr32];
  end

  always @(posedge clk) begin
    if (bd_we64) mem64[bd_addr] <= bd_data;
    else if (mwe64) mem64[maddr64] <= mwd64;
    mrd64 <= mem64[maddr64];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // All tasks below start and end at #1 after a rising edge.
  task automatic poke32(input logic [16:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we32 = 1'b1;
    @(posedge clk); #1;
    bd_we32 = 1'b0;
  endtask

  task automatic poke64(input logic [16:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we64 = 1'b1;
    @(posedge clk); #1;
    bd_we64 = 1'b0;
  endtask

  // Present a request and return #1 after the edge that accepted it.
  task automatic issue32(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [16:0] a, input logic [31:0] wd, input bit keep);
    bit got = 0;
    rwe32 = we; rsz32 = sz; run32 = uns; raddr32 = a; rwd32 = wd; rv32 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (rr32) begin
        got = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!keep) rv32 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL accept32: req_ready got 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue64(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [16:0] a, input logic [63:0] wd);
    bit got = 0;
    rwe64 = we; rsz64 = sz; run64 = uns; raddr64 = a; rwd64 = wd; rv64 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (rr64) begin
        got = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    rv64 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL accept64: req_ready got 0 expected 1 within 20 cycles");
    end
  endtask

  // lat = edge number that consumes the pulse; 0 means it never came.
  task automatic wait_resp32(input int start, output int lat);
    lat = 0;
    for (int j = start + 1; j <= start + 40; j++) begin
      @(posedge clk); #1;
      if (respv32) begin
        lat = j + 1;
        break;
      end
    end
  endtask

  task automatic wait_resp64(input int start, output int lat);
    lat = 0;
    for (int j = start + 1; j <= start + 40; j++) begin
      @(posedge clk); #1;
      if (respv64) begin
        lat = j + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rr32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", rr32); end
    checks++; if (respv32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", respv32); end
    checks++; if (rdata32 !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h expected 0", rdata32); end
    checks++; if (maddr32 !== 17'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", maddr32); end
    checks++; if (mwe32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mwe32); end
    checks++; if (mwd32 !== 8'h0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mwd32); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rr32 !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_rst32: got %b expected 1", rr32); end
    checks++; if (rr64 !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_rst64: got %b expected 1", rr64); end
  endtask

  task automatic test_word_load;
    int lat;
    poke32(17'h00100, 8'h11); poke32(17'h00101, 8'h22);
    poke32(17'h00102, 8'h33); poke32(17'h00103, 8'h44);
    issue32(1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, 1'b0);
    wait_resp32(0, lat);
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL word_load_latency: got %0d expected 6", lat); end
    checks++; if (rdata32 !== 32'h44332211) begin errors++; $display("[TB] FAIL word_load_data: got %h expected 44332211", rdata32); end
    @(posedge clk); #1;
    checks++; if (respv32 !== 1'b0) begin errors++; $display("[TB] FAIL word_load_pulse: got %b expected 0", respv32); end
  endtask

  task automatic test_load_ext;
    int lat;
    poke32(17'h00200, 8'h80);
    poke32(17'h00210, 8'h01); poke32(17'h00211, 8'h80);
    issue32(1'b0, 2'd0, 1'b0, 17'h00200, 32'h0, 1'b0);
    wait_resp32(0, lat);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL byte_load_latency: got %0d expected 3", lat); end
    checks++; if (rdata32 !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL byte_signed: got %h expected ffffff80", rdata32); end
    issue32(1'b0, 2'd0, 1'b1, 17'h00200, 32'h0, 1'b0);
    wait_resp32(0, lat);
    checks++; if (rdata32 !== 32'h00000080) begin errors++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", rdata32); end
    issue32(1'b0, 2'd1, 1'b0, 17'h00210, 32'h0, 1'b0);
    wait_resp32(0, lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL half_load_latency: got %0d expected 4", lat); end
    checks++; if (rdata32 !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL half_signed: got %h expected ffff8001", rdata32); end
  endtask

  task automatic test_store_half_wrap;
    poke32(17'h1FFFF, 8'h00); poke32(17'h00000, 8'h00);
    issue32(1'b1, 2'd1, 1'b0, 17'h1FFFF, 32'h0000BEEF, 1'b0);
    checks++;
    if (mwe32 !== 1'b1 || maddr32 !== 17'h1FFFF || mwd32 !== 8'hEF) begin
      errors++; $display("[TB] FAIL store_byte0: got we=%b addr=%h data=%h expected we=1 addr=1ffff data=ef", mwe32, maddr32, mwd32);
    end
    @(posedge clk); #1;
    checks++;
    if (mwe32 !== 1'b1 || maddr32 !== 17'h00000 || mwd32 !== 8'hBE) begin
      errors++; $display("[TB] FAIL store_byte1_wrap: got we=%b addr=%h data=%h expected we=1 addr=00000 data=be", mwe32, maddr32, mwd32);
    end
    @(posedge clk); #1;
    checks++;
    if (respv32 !== 1'b1 || mwe32 !== 1'b0) begin
      errors++; $display("[TB] FAIL store_resp_at_3: got resp=%b we=%b expected resp=1 we=0", respv32, mwe32);
    end
    checks++; if (mem32[17'h1FFFF] !== 8'hEF) begin errors++; $display("[TB] FAIL mem_1ffff: got %h expected ef", mem32[17'h1FFFF]); end
    checks++; if (mem32[17'h00000] !== 8'hBE) begin errors++; $display("[TB] FAIL mem_00000: got %h expected be", mem32[17'h00000]); end
    checks++; if (rdata32 !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL store_keeps_rdata: got %h expected ffff8001", rdata32); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    int wc;
    bit busy_ready = 0;
    poke32(17'h00400, 8'h77);
    issue32(1'b1, 2'd2, 1'b0, 17'h00300, 32'hCAFEF00D, 1'b1);
    rwe32 = 1'b0; rsz32 = 2'd0; run32 = 1'b0; raddr32 = 17'h00302;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk); #1;
      if (rr32 !== 1'b0) busy_ready = 1;
    end
    checks++; if (busy_ready) begin errors++; $display("[TB] FAIL b2b_ready_busy: got 1 expected 0 during store"); end
    @(posedge clk); #1;
    checks++;
    if (respv32 !== 1'b1 || rr32 !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_store_resp: got resp=%b ready=%b expected 1 1", respv32, rr32);
    end
    @(posedge clk); #1;
    checks++;
    if (respv32 !== 1'b0 || maddr32 !== 17'h00302 || mwe32 !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_load_started: got resp=%b addr=%h we=%b expected 0 00302 0", respv32, maddr32, mwe32);
    end
    wc = wr_count32;
    rwe32 = 1'b1; raddr32 = 17'h00400; rwd32 = 32'h0000005A;
    @(posedge clk); #1;
    rv32 = 1'b0;
    wait_resp32(1, lat);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL b2b_load_latency: got %0d expected 3", lat); end
    checks++; if (rdata32 !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL b2b_load_data: got %h expected fffffffe", rdata32); end
    checks++;
    if ({mem32[17'h303], mem32[17'h302], mem32[17'h301], mem32[17'h300]} !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL b2b_store_mem: got %h%h%h%h expected cafef00d", mem32[17'h303], mem32[17'h302], mem32[17'h301], mem32[17'h300]);
    end
    checks++; if (mem32[17'h00400] !== 8'h77) begin errors++; $display("[TB] FAIL ignored_req_mem: got %h expected 77", mem32[17'h00400]); end
    checks++; if (wr_count32 != wc) begin errors++; $display("[TB] FAIL ignored_req_writes: got %0d expected %0d", wr_count32, wc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int wc;
    bit saw_resp = 0;
    poke32(17'h00500, 8'h00); poke32(17'h00501, 8'h00);
    poke32(17'h00502, 8'h00); poke32(17'h00503, 8'h00);
    wc = wr_count32;
    issue32(1'b1, 2'd2, 1'b0, 17'h00500, 32'hA1B2C3D4, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (mwe32 !== 1'b0) begin errors++; $display("[TB] FAIL abort_we_async: got %b expected 0", mwe32); end
    checks++; if (rr32 !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready_in_rst: got %b expected 0", rr32); end
    checks++; if (rdata32 !== 32'h0) begin errors++; $display("[TB] FAIL abort_rdata_cleared: got %h expected 0", rdata32); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rr32 !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready_after: got %b expected 1", rr32); end
    for (int j = 0; j < 8; j++) begin
      if (respv32 !== 1'b0) saw_resp = 1;
      @(posedge clk); #1;
    end
    checks++; if (saw_resp) begin errors++; $display("[TB] FAIL abort_no_resp: got 1 expected 0"); end
    checks++; if (wr_count32 - wc != 2) begin errors++; $display("[TB] FAIL abort_write_count: got %0d expected 2", wr_count32 - wc); end
    checks++;
    if ({mem32[17'h503], mem32[17'h502], mem32[17'h501], mem32[17'h500]} !== 32'h0000C3D4) begin
      errors++; $display("[TB] FAIL abort_mem: got %h%h%h%h expected 0000c3d4", mem32[17'h503], mem32[17'h502], mem32[17'h501], mem32[17'h500]);
    end
  endtask

  task automatic test_dword_64;
    int lat;
    poke64(17'h1FFFC, 8'h01); poke64(17'h1FFFD, 8'h02);
    poke64(17'h1FFFE, 8'h03); poke64(17'h1FFFF, 8'h04);
    poke64(17'h00000, 8'h05); poke64(17'h00001, 8'h06);
    poke64(17'h00002, 8'h07); poke64(17'h00003, 8'h08);
    issue64(1'b0, 2'd3, 1'b0, 17'h1FFFC, 64'h0);
    wait_resp64(0, lat);
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL dword_latency: got %0d expected 10", lat); end
    checks++; if (rdata64 !== 64'h0807060504030201) begin errors++; $display("[TB] FAIL dword_data: got %h expected 0807060504030201", rdata64); end
    poke64(17'h00600, 8'h00); poke64(17'h00601, 8'h00);
    poke64(17'h00602, 8'h00); poke64(17'h00603, 8'h80);
    issue64(1'b0, 2'd2, 1'b0, 17'h00600, 64'h0);
    wait_resp64(0, lat);
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL word64_latency: got %0d expected 6", lat); end
    checks++; if (rdata64 !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL word64_signed: got %h expected ffffffff80000000", rdata64); end
    issue32(1'b0, 2'd3, 1'b1, 17'h00100, 32'h0, 1'b0);
    wait_resp32(0, lat);
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL size3_len32_latency: got %0d expected 6", lat); end
    checks++; if (rdata32 !== 32'h44332211) begin errors++; $display("[TB] FAIL size3_len32_data: got %h expected 44332211", rdata32); end
  endtask

  initial begin
    $display("[TB] mem_byte_bridge bench start");
    test_reset;
    test_word_load;
    test_load_ext;
    test_store_half_wrap;
    test_back_to_back;
    test_reset_abort;
    test_dword_64;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
